// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and per-source candidate helpers for the interrupt controller.
// Optional IRQ_CONTROLLER_NMI_EN makes source 0 non-maskable in src_cand.
package irq_pkg;
    localparam int NUM_GROUPS    = 8;
    localparam int SRC_PER_GROUP = 4;
    localparam int NSRC          = NUM_GROUPS * SRC_PER_GROUP;

    localparam logic [3:0] PRI_L = 4'd0;
    localparam logic [3:0] PRI_H = 4'd1;
    localparam logic [3:0] ENA0  = 4'd2;
    localparam logic [3:0] ENA1  = 4'd3;
    localparam logic [3:0] ENA2  = 4'd4;
    localparam logic [3:0] ENA3  = 4'd5;
    localparam logic [3:0] ACT0  = 4'd6;
    localparam logic [3:0] ACT1  = 4'd7;
    localparam logic [3:0] ACT2  = 4'd8;
    localparam logic [3:0] ACT3  = 4'd9;
    localparam logic [3:0] NUM_REGS = 4'd10;

    typedef enum logic [1:0] {IDLE, PENDING, ACKED} irq_state_e;

    function automatic logic [1:0] group_pri(input logic [15:0] pri, input logic [2:0] grp);
        return pri[{grp, 1'b0} +: 2];
    endfunction

    function automatic logic src_cand(input logic [NSRC-1:0] act, input logic [NSRC-1:0] ena,
                                      input logic [15:0] pri, input logic [1:0] level,
                                      input logic [4:0] src);
`ifdef IRQ_CONTROLLER_NMI_EN
        if (src == 5'd0) return act[0];
`endif
        return act[src] & ena[src] & (group_pri(pri, src[4:2]) > level);
    endfunction
endpackage

// File: rtl/irq_arbiter.sv
// Combinational pick of the highest-priority candidate source; ties go to the lowest index.
// Zero latency; valid_o low when nothing qualifies.
module irq_arbiter
    import irq_pkg::*;
(
    input  logic [NSRC-1:0] act_i,
    input  logic [NSRC-1:0] ena_i,
    input  logic [15:0]     pri_i,
    input  logic [1:0]      level_i,
    output logic            valid_o,
    output logic [4:0]      winner_o,
    output logic [1:0]      winner_pri_o
);
    always_comb begin
        valid_o      = 1'b0;
        winner_o     = 5'd0;
        winner_pri_o = 2'd0;
        // Ascending scan with strict compare keeps the lowest index on a priority tie.
        for (int n = 0; n < NSRC; n++) begin
            if (src_cand(act_i, ena_i, pri_i, level_i, 5'(n)) &&
                (!valid_o || group_pri(pri_i, 3'(n >> 2)) > winner_pri_o)) begin
                valid_o      = 1'b1;
                winner_o     = 5'(n);
                winner_pri_o = group_pri(pri_i, 3'(n >> 2));
            end
        end
`ifdef IRQ_CONTROLLER_NMI_EN
        if (act_i[0]) begin
            valid_o      = 1'b1;
            winner_o     = 5'd0;
            winner_pri_o = 2'd3;
        end
`endif
    end
endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pulse latching, enables, group priorities, req/vector/ack handshake.
// irq_in at clk_ce cycle t -> ACT at t+1 -> irq_req at t+2; define IRQ_CONTROLLER_NMI_EN for non-maskable source 0.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC     = 32,
    parameter logic [23:0] IRQ_BASE    = 24'h002020,
    parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_ce,
    input  logic               bus_write,
    input  logic               bus_read,
    input  logic [23:0]        bus_address_in,
    input  logic [7:0]         bus_data_in,
    output logic [7:0]         bus_data_out,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [1:0]         cpu_level,
    output logic               irq_req,
    output logic [7:0]         irq_vector,
    input  logic               irq_ack
);
    logic [15:0]     pri_q, pri_d;
    logic [NSRC-1:0] ena_q, ena_d;
    logic [NSRC-1:0] act_q, act_d, act_clr;
    irq_state_e      state_q, state_d;
    logic [7:0]      vec_q, vec_d;
    logic [4:0]      src_q, src_d;

    logic [23:0] addr_rel;
    logic        addr_hit;
    logic [3:0]  addr_off;
    logic        arb_valid;
    logic [4:0]  arb_winner;
    logic [1:0]  unused_arb_pri;
    logic        unused_bus_read;

    assign unused_bus_read = bus_read;
    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    assign addr_rel = bus_address_in - IRQ_BASE;
    assign addr_hit = addr_rel < 24'(NUM_REGS);
    assign addr_off = addr_rel[3:0];

    always_comb begin
        bus_data_out = 8'h00;
        if (addr_hit) begin
            case (addr_off)
                PRI_L:   bus_data_out = pri_q[7:0];
                PRI_H:   bus_data_out = pri_q[15:8];
                ENA0:    bus_data_out = ena_q[7:0];
                ENA1:    bus_data_out = ena_q[15:8];
                ENA2:    bus_data_out = ena_q[23:16];
                ENA3:    bus_data_out = ena_q[31:24];
                ACT0:    bus_data_out = act_q[7:0];
                ACT1:    bus_data_out = act_q[15:8];
                ACT2:    bus_data_out = act_q[23:16];
                ACT3:    bus_data_out = act_q[31:24];
                default: bus_data_out = 8'h00;
            endcase
        end
    end

    always_comb begin
        pri_d   = pri_q;
        ena_d   = ena_q;
        act_clr = '0;
        if (bus_write && addr_hit) begin
            case (addr_off)
                PRI_L:   pri_d[7:0]     = bus_data_in;
                PRI_H:   pri_d[15:8]    = bus_data_in;
                ENA0:    ena_d[7:0]     = bus_data_in;
                ENA1:    ena_d[15:8]    = bus_data_in;
                ENA2:    ena_d[23:16]   = bus_data_in;
                ENA3:    ena_d[31:24]   = bus_data_in;
                ACT0:    act_clr[7:0]   = bus_data_in;
                ACT1:    act_clr[15:8]  = bus_data_in;
                ACT2:    act_clr[23:16] = bus_data_in;
                ACT3:    act_clr[31:24] = bus_data_in;
                default: ;
            endcase
        end
        // A fresh pulse overrides a software clear of the same bit.
        act_d = (act_q & ~act_clr) | irq_in;
    end

    irq_arbiter u_arbiter (
        .act_i        (act_q),
        .ena_i        (ena_q),
        .pri_i        (pri_q),
        .level_i      (cpu_level),
        .valid_o      (arb_valid),
        .winner_o     (arb_winner),
        .winner_pri_o (unused_arb_pri)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = PENDING;
                    vec_d   = VECTOR_BASE + {3'b000, arb_winner};
                    src_d   = arb_winner;
                end
            end
            PENDING: begin
                if (irq_ack)
                    state_d = ACKED;
                else if (!src_cand(act_q, ena_q, pri_q, cpu_level, src_q))
                    state_d = IDLE;
            end
            ACKED:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pri_q   <= '0;
            ena_q   <= '0;
            act_q   <= '0;
            state_q <= IDLE;
            vec_q   <= 8'h00;
            src_q   <= 5'd0;
        end else if (clk_ce) begin
            pri_q   <= pri_d;
            ena_q   <= ena_d;
            act_q   <= act_d;
            state_q <= state_d;
            vec_q   <= vec_d;
            src_q   <= src_d;
        end
    end

    assign irq_req    = (state_q == PENDING);
    assign irq_vector = vec_q;
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboarded bench for irq_controller: register access, arbitration, handshake, clk_ce freeze, reset.
module tb_irq_controller;
    localparam logic [23:0] BASE = 24'h002020;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [31:0] irq_in;
    logic [1:0]  cpu_level;
    logic        irq_req;
    logic [7:0]  irq_vector;
    logic        irq_ack;

    irq_controller dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce         (clk_ce),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_in         (irq_in),
        .cpu_level      (cpu_level),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_ack        (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [7:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got %h expected none", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [7:0] data);
        bus_address_in = BASE + 24'(off);
        bus_data_in    = data;
        bus_write      = 1'b1;
        tick();
        bus_write      = 1'b0;
    endtask

    task automatic bus_rd(input logic [23:0] addr, output logic [7:0] data);
        bus_address_in = addr;
        bus_read       = 1'b1;
        #1;
        data           = bus_data_out;
        bus_read       = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] mask);
        irq_in = mask;
        tick();
        irq_in = '0;
    endtask

    logic [7:0] rdat;

    initial begin
        reset = 1'b0; clk_ce = 1'b1; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = '0; bus_data_in = '0; irq_in = '0; cpu_level = 2'd0; irq_ack = 1'b0;
        #2;
        expect_val("rst_req", 8'h00);  observe({7'b0, irq_req});
        expect_val("rst_vec", 8'h00);  observe(irq_vector);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic path: source 0, group 0 priority 1.
        bus_wr(4'd0, 8'h01); bus_wr(4'd1, 8'h00); bus_wr(4'd2, 8'h01);
        expect_val("pri_l_rb", 8'h01); bus_rd(BASE + 24'd0, rdat); observe(rdat);
        pulse(32'h1);
        expect_val("act0_set", 8'h01); bus_rd(BASE + 24'd6, rdat); observe(rdat);
        expect_val("req_t1", 8'h00);   observe({7'b0, irq_req});
        tick();
        expect_val("req_t2", 8'h01);   observe({7'b0, irq_req});
        expect_val("vec_src0", 8'h03); observe(irq_vector);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        expect_val("acked_req", 8'h00); observe({7'b0, irq_req});
        bus_wr(4'd6, 8'h01);
        tick();
        expect_val("idle_after_clr", 8'h00); observe({7'b0, irq_req});

        // Priority: source 1 (prio 1) against source 9 (prio 3).
        bus_wr(4'd0, 8'h31); bus_wr(4'd2, 8'h02); bus_wr(4'd3, 8'h02);
        pulse(32'h0000_0202);
        tick();
        expect_val("vec_src9", 8'h0C); observe(irq_vector);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        bus_wr(4'd7, 8'h02);
        tick();
        expect_val("req_src1", 8'h01); observe({7'b0, irq_req});
        expect_val("vec_src1", 8'h04); observe(irq_vector);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        bus_wr(4'd6, 8'h02);
        bus_wr(4'd3, 8'h00);
        tick();

        // cpu_level masking, then hold-off of a later higher-priority source and withdrawal.
        cpu_level = 2'd1;
        bus_wr(4'd0, 8'h01); bus_wr(4'd2, 8'h04);
        pulse(32'h4);
        tick(); tick();
        expect_val("masked_req", 8'h00); observe({7'b0, irq_req});
        cpu_level = 2'd0;
        tick();
        expect_val("unmask_req", 8'h01); observe({7'b0, irq_req});
        expect_val("vec_src2", 8'h05);   observe(irq_vector);
        bus_wr(4'd0, 8'h31); bus_wr(4'd3, 8'h02);
        pulse(32'h0000_0200);
        tick();
        expect_val("hold_vec", 8'h05); observe(irq_vector);
        bus_wr(4'd6, 8'h04);
        tick();
        expect_val("withdraw_req", 8'h00); observe({7'b0, irq_req});
        tick();
        expect_val("repick_vec", 8'h0C); observe(irq_vector);
        bus_wr(4'd7, 8'h02);
        tick();
        expect_val("withdraw2_req", 8'h00); observe({7'b0, irq_req});

        // Set beats same-cycle clear; ack in IDLE is ignored.
        irq_in = 32'h8; bus_address_in = BASE + 24'd6; bus_data_in = 8'h08; bus_write = 1'b1;
        tick();
        irq_in = '0; bus_write = 1'b0;
        expect_val("set_wins", 8'h08); bus_rd(BASE + 24'd6, rdat); observe(rdat);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
        expect_val("idle_ack_req", 8'h00); observe({7'b0, irq_req});
        bus_wr(4'd6, 8'h08);

        // Out-of-map reads.
        expect_val("oor_hi", 8'h00); bus_rd(BASE + 24'd10, rdat); observe(rdat);
        expect_val("oor_lo", 8'h00); bus_rd(BASE - 24'd1, rdat); observe(rdat);

        // clk_ce low freezes state; reads still follow the address.
        clk_ce = 1'b0;
        irq_in = 32'h4;
        tick(); tick(); tick();
        irq_in = '0;
        expect_val("frz_act", 8'h00); bus_rd(BASE + 24'd6, rdat); observe(rdat);
        expect_val("frz_ena", 8'h04); bus_rd(BASE + 24'd2, rdat); observe(rdat);
        expect_val("frz_req", 8'h00); observe({7'b0, irq_req});
        clk_ce = 1'b1;

        // Reset in the middle of a pending request.
        pulse(32'h4);
        tick();
        expect_val("pre_rst_req", 8'h01); observe({7'b0, irq_req});
        #2 reset = 1'b0;
        #1;
        expect_val("async_drop", 8'h00); observe({7'b0, irq_req});
        expect_val("rst_pri", 8'h00); bus_rd(BASE + 24'd0, rdat); observe(rdat);
        expect_val("rst_ena", 8'h00); bus_rd(BASE + 24'd2, rdat); observe(rdat);
        expect_val("rst_act", 8'h00); bus_rd(BASE + 24'd6, rdat); observe(rdat);
        tick();
        reset = 1'b1;
        tick();

        // Source 0 with everything masked: only the NMI build should request.
        cpu_level = 2'd3;
        pulse(32'h1);
        tick();
`ifdef IRQ_CONTROLLER_NMI_EN
        expect_val("nmi_req", 8'h01); observe({7'b0, irq_req});
        expect_val("nmi_vec", 8'h03); observe(irq_vector);
`else
        expect_val("src0_masked", 8'h00); observe({7'b0, irq_req});
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
